// File: rtl/instr_seq_dec_pkg.sv
// rtl/instr_seq_dec_pkg.sv - shared codes, state encoding and helpers for the sequential decoder
package instr_seq_dec_pkg;

  localparam logic [1:0] FMT_ILL = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_II  = 2'd2;
  localparam logic [1:0] FMT_J   = 2'd3;

  localparam logic [1:0] AS_REG  = 2'd0;
  localparam logic [1:0] AS_IDX  = 2'd1;
  localparam logic [1:0] AS_IND  = 2'd2;
  localparam logic [1:0] AS_AUTO = 2'd3;

  localparam logic [3:0] CG_R2 = 4'd2;
  localparam logic [3:0] CG_R3 = 4'd3;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_SRC_EXT = 2'd1,
    S_DST_EXT = 2'd2,
    S_ISSUE   = 2'd3
  } state_t;

  // Extension-word counter: sticks at 2, never wraps.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd2 : v + 2'd1;
  endfunction

endpackage

// File: rtl/instr_seq_dec_if.sv
// rtl/instr_seq_dec_if.sv - fetch path and decoded-bundle handshake between fetch, decoder and execute
interface instr_seq_dec_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          fetch_req;
  logic          fetch_ack;
  logic [DW-1:0] mdb_in;
  logic          pc_inc;
  logic          dec_valid;
  logic          dec_ready;
  logic [15:0]   ir;
  logic [1:0]    fmt;
  logic [1:0]    as_mode;
  logic          ad_mode;
  logic          bw;
  logic [3:0]    reg_sa;
  logic [3:0]    reg_da;
  logic [DW-1:0] src_ext;
  logic [DW-1:0] dst_ext;
  logic [1:0]    n_ext;
  logic          cg_hit;
  logic [AW-1:0] jmp_off;
  logic          illegal;

  modport master (
    input  fetch_ack, mdb_in, dec_ready,
    output fetch_req, pc_inc, dec_valid, ir, fmt, as_mode, ad_mode, bw,
           reg_sa, reg_da, src_ext, dst_ext, n_ext, cg_hit, jmp_off, illegal
  );

  modport slave (
    output fetch_ack, mdb_in, dec_ready,
    input  fetch_req, pc_inc, dec_valid, ir, fmt, as_mode, ad_mode, bw,
           reg_sa, reg_da, src_ext, dst_ext, n_ext, cg_hit, jmp_off, illegal
  );
endinterface

// File: rtl/instr_fields.sv
// rtl/instr_fields.sv - combinational MSP430 opcode field extractor (requires AW >= 12)
module instr_fields
  import instr_seq_dec_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [15:0]   word,
  output logic [1:0]    fmt,
  output logic [1:0]    as_mode,
  output logic          ad,
  output logic          bw,
  output logic [3:0]    sa,
  output logic [3:0]    da,
  output logic          needs_src,
  output logic          needs_dst,
  output logic          cg_hit,
  output logic [AW-1:0] jmp_off
);

  always_comb begin
    fmt     = FMT_ILL;
    as_mode = AS_REG;
    ad      = 1'b0;
    bw      = 1'b0;
    sa      = 4'd0;
    da      = 4'd0;
    jmp_off = '0;
    if (word[15:14] != 2'b00) begin
      fmt     = FMT_I;
      sa      = word[11:8];
      ad      = word[7];
      bw      = word[6];
      as_mode = word[5:4];
      da      = word[3:0];
    end else if (word[15:13] == 3'b001) begin
      fmt     = FMT_J;
      jmp_off = {{(AW-11){word[9]}}, word[9:0], 1'b0};
    end else if (word[15:10] == 6'b000100) begin
      fmt     = FMT_II;
      sa      = word[3:0];
      da      = word[3:0];
      bw      = word[6];
      as_mode = word[5:4];
    end
    // Constant generator supplies the operand, so it never costs an extension word.
    cg_hit    = (fmt == FMT_I || fmt == FMT_II) &&
                (sa == CG_R3 || (sa == CG_R2 && (as_mode == AS_IND || as_mode == AS_AUTO)));
    needs_src = (fmt == FMT_I || fmt == FMT_II) && !cg_hit &&
                ((as_mode == AS_IDX && sa != CG_R3) || (as_mode == AS_AUTO && sa == 4'd0));
    needs_dst = (fmt == FMT_I) && ad;
  end

endmodule

// File: rtl/instr_seq_dec.sv
// rtl/instr_seq_dec.sv - FSM that fetches an opcode plus extension words and issues a registered bundle
module instr_seq_dec
  import instr_seq_dec_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int OUT_REG = 1
) (
  input logic               clk,
  input logic               rst_n,
  input logic               flush,
  instr_seq_dec_if.master   bus
);

  localparam logic DV_ON_ENTRY = (OUT_REG == 0);

  state_t        state;
  logic          need_dst;
  logic [DW-1:0] src_q, dst_q;

  logic [1:0]    f_fmt, f_as;
  logic          f_ad, f_bw, f_ns, f_nd, f_cg;
  logic [3:0]    f_sa, f_da;
  logic [AW-1:0] f_jmp;
  logic          take;

  instr_fields #(.AW(AW)) u_fields (
    .word      (bus.mdb_in[15:0]),
    .fmt       (f_fmt),
    .as_mode   (f_as),
    .ad        (f_ad),
    .bw        (f_bw),
    .sa        (f_sa),
    .da        (f_da),
    .needs_src (f_ns),
    .needs_dst (f_nd),
    .cg_hit    (f_cg),
    .jmp_off   (f_jmp)
  );

  assign take        = bus.fetch_req & bus.fetch_ack & ~flush;
  assign bus.pc_inc  = take;
  assign bus.src_ext = src_q;
  assign bus.dst_ext = dst_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      need_dst      <= 1'b0;
      bus.fetch_req <= 1'b0;
      bus.dec_valid <= 1'b0;
      bus.ir        <= 16'd0;
      bus.fmt       <= FMT_ILL;
      bus.as_mode   <= AS_REG;
      bus.ad_mode   <= 1'b0;
      bus.bw        <= 1'b0;
      bus.reg_sa    <= 4'd0;
      bus.reg_da    <= 4'd0;
      src_q         <= '0;
      dst_q         <= '0;
      bus.n_ext     <= 2'd0;
      bus.cg_hit    <= 1'b0;
      bus.jmp_off   <= '0;
      bus.illegal   <= 1'b0;
    end else if (flush) begin
      state         <= S_FETCH;
      bus.fetch_req <= 1'b1;
      bus.dec_valid <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          bus.fetch_req <= 1'b1;
          if (take) begin
            bus.ir      <= bus.mdb_in[15:0];
            bus.fmt     <= f_fmt;
            bus.as_mode <= f_as;
            bus.ad_mode <= f_ad;
            bus.bw      <= f_bw;
            bus.reg_sa  <= f_sa;
            bus.reg_da  <= f_da;
            bus.cg_hit  <= f_cg;
            bus.jmp_off <= f_jmp;
            bus.illegal <= (bus.mdb_in[15:12] == 4'd0);
            src_q       <= '0;
            dst_q       <= '0;
            bus.n_ext   <= 2'd0;
            need_dst    <= f_nd;
            if (f_ns) begin
              state <= S_SRC_EXT;
            end else if (f_nd) begin
              state <= S_DST_EXT;
            end else begin
              state         <= S_ISSUE;
              bus.fetch_req <= 1'b0;
              bus.dec_valid <= DV_ON_ENTRY;
            end
          end
        end
        S_SRC_EXT: begin
          if (take) begin
            src_q     <= bus.mdb_in;
            bus.n_ext <= sat_inc2(bus.n_ext);
            if (need_dst) begin
              state <= S_DST_EXT;
            end else begin
              state         <= S_ISSUE;
              bus.fetch_req <= 1'b0;
              bus.dec_valid <= DV_ON_ENTRY;
            end
          end
        end
        S_DST_EXT: begin
          if (take) begin
            dst_q         <= bus.mdb_in;
            bus.n_ext     <= sat_inc2(bus.n_ext);
            state         <= S_ISSUE;
            bus.fetch_req <= 1'b0;
            bus.dec_valid <= DV_ON_ENTRY;
          end
        end
        S_ISSUE: begin
          // With the output stage enabled, valid rises one cycle after entering ISSUE.
          if (!bus.dec_valid) begin
            bus.dec_valid <= 1'b1;
          end else if (bus.dec_ready) begin
            state         <= S_FETCH;
            bus.fetch_req <= 1'b1;
            bus.dec_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_seq_dec.sv
// tb/tb_instr_seq_dec.sv - self-checking bench for instr_seq_dec (table vectors, corner sequences, random)
module tb_instr_seq_dec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   pc_cnt = 0;

  instr_seq_dec_if #(.AW(16), .DW(16)) bus ();

  instr_seq_dec #(.AW(16), .DW(16), .OUT_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.pc_inc === 1'b1) pc_cnt++;

  typedef struct {
    logic [1:0]  fmt;
    logic [1:0]  as_mode;
    logic        ad;
    logic        bw;
    logic [3:0]  sa;
    logic [3:0]  da;
    logic [15:0] src;
    logic [15:0] dst;
    logic [1:0]  n;
    logic        cg;
    logic [15:0] jmp;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [15:0] op;
    logic [15:0] w1;
    logic [15:0] w2;
    int          gap;
    int          hold;
    exp_t        e;
  } vec_t;

  function automatic exp_t mk(int fmt, int as_mode, int ad, int bw, int sa, int da,
                              int src, int dst, int n, int cg, int jmp, int ill);
    exp_t e;
    e.fmt = 2'(fmt);   e.as_mode = 2'(as_mode); e.ad = 1'(ad);   e.bw = 1'(bw);
    e.sa = 4'(sa);     e.da = 4'(da);           e.src = 16'(src); e.dst = 16'(dst);
    e.n = 2'(n);       e.cg = 1'(cg);           e.jmp = 16'(jmp); e.ill = 1'(ill);
    return e;
  endfunction

  // Transaction-level reference: decode the opcode from the ISA rules, then place extension words.
  function automatic exp_t model(input logic [15:0] op, input logic [15:0] w1, input logic [15:0] w2);
    exp_t e;
    int   top, off;
    bit   ns, nd;
    e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    top = int'(op[15:12]);
    ns = 1'b0;
    e.ill = (top == 0);
    if (top >= 4) begin
      e.fmt = 2'd1; e.sa = op[11:8]; e.ad = op[7]; e.bw = op[6]; e.as_mode = op[5:4]; e.da = op[3:0];
    end else if (top >= 2) begin
      e.fmt = 2'd3;
      off = int'(op[9:0]);
      if (off >= 512) off -= 1024;
      e.jmp = 16'(off * 2);
    end else if (top == 1 && op[11:10] == 2'b00) begin
      e.fmt = 2'd2; e.sa = op[3:0]; e.da = op[3:0]; e.bw = op[6]; e.as_mode = op[5:4];
    end
    if (e.fmt == 2'd1 || e.fmt == 2'd2) begin
      e.cg = (e.sa == 4'd3) || (e.sa == 4'd2 && e.as_mode >= 2'd2);
      ns = !e.cg && (e.as_mode == 2'd1 || (e.as_mode == 2'd3 && e.sa == 4'd0));
    end
    nd = (e.fmt == 2'd1) && e.ad;
    e.n = 2'(int'(ns) + int'(nd));
    e.src = ns ? w1 : 16'h0;
    e.dst = nd ? (ns ? w2 : w1) : 16'h0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input logic [15:0] ir, input exp_t e);
    chk({tag, ".ir"},      32'(bus.ir),      32'(ir));
    chk({tag, ".fmt"},     32'(bus.fmt),     32'(e.fmt));
    chk({tag, ".as"},      32'(bus.as_mode), 32'(e.as_mode));
    chk({tag, ".ad"},      32'(bus.ad_mode), 32'(e.ad));
    chk({tag, ".bw"},      32'(bus.bw),      32'(e.bw));
    chk({tag, ".sa"},      32'(bus.reg_sa),  32'(e.sa));
    chk({tag, ".da"},      32'(bus.reg_da),  32'(e.da));
    chk({tag, ".src_ext"}, 32'(bus.src_ext), 32'(e.src));
    chk({tag, ".dst_ext"}, 32'(bus.dst_ext), 32'(e.dst));
    chk({tag, ".n_ext"},   32'(bus.n_ext),   32'(e.n));
    chk({tag, ".cg_hit"},  32'(bus.cg_hit),  32'(e.cg));
    chk({tag, ".jmp_off"}, 32'(bus.jmp_off), 32'(e.jmp));
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".fetch_req"}, 32'(bus.fetch_req), 0);
    chk({tag, ".dec_valid"}, 32'(bus.dec_valid), 0);
    chk({tag, ".pc_inc"},    32'(bus.pc_inc),    0);
    chk({tag, ".ir"},        32'(bus.ir),        0);
    chk({tag, ".fmt"},       32'(bus.fmt),       0);
    chk({tag, ".n_ext"},     32'(bus.n_ext),     0);
    chk({tag, ".src_ext"},   32'(bus.src_ext),   0);
    chk({tag, ".dst_ext"},   32'(bus.dst_ext),   0);
    chk({tag, ".jmp_off"},   32'(bus.jmp_off),   0);
    chk({tag, ".cg_hit"},    32'(bus.cg_hit),    0);
    chk({tag, ".illegal"},   32'(bus.illegal),   0);
  endtask

  // Entered and left at a falling edge with the decoder idle in FETCH.
  task automatic run_instr(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input exp_t e, input int gap, input int hold, input string tag);
    logic [15:0] words [3];
    int nw, k, pc0;
    words[0] = w0; words[1] = w1; words[2] = w2;
    nw = 1 + int'(e.n);
    pc0 = pc_cnt;
    for (int i = 0; i < nw; i++) begin
      repeat (gap) @(posedge clk);
      @(posedge clk); #1;
      bus.fetch_ack = 1'b1;
      bus.mdb_in = words[i];
      @(negedge clk);
      k = 0;
      while (bus.fetch_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
      chk({tag, ".ack_pc_inc"}, 32'(bus.pc_inc), 1);
      @(posedge clk); #1;
      bus.fetch_ack = 1'b0;
    end
    @(negedge clk);
    k = 0;
    while (bus.dec_valid !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    chk({tag, ".latency"}, 32'(k), 1);
    chk({tag, ".issue_fetch_req"}, 32'(bus.fetch_req), 0);
    chk({tag, ".pc_inc_count"}, 32'(pc_cnt - pc0), 32'(nw));
    chk_bundle(tag, w0, e);
    repeat (hold) begin
      @(negedge clk);
      chk({tag, ".hold_valid"},     32'(bus.dec_valid), 1);
      chk({tag, ".hold_fetch_req"}, 32'(bus.fetch_req), 0);
      chk({tag, ".hold_ir"},        32'(bus.ir),        32'(w0));
      chk({tag, ".hold_src"},       32'(bus.src_ext),   32'(e.src));
    end
    bus.dec_ready = 1'b1;
    @(posedge clk); #1;
    bus.dec_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".post_valid"},     32'(bus.dec_valid), 0);
    chk({tag, ".post_fetch_req"}, 32'(bus.fetch_req), 1);
  endtask

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] op, w1, w2;
    exp_t e;

    tbl[0]  = '{16'h4405, 16'h0000, 16'h0000, 0, 0, mk(1, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{16'h4035, 16'h1234, 16'h0000, 0, 1, mk(1, 3, 0, 0, 0, 5, 'h1234, 0, 1, 0, 0, 0)};
    tbl[2]  = '{16'h4495, 16'h0002, 16'h0004, 1, 0, mk(1, 1, 1, 0, 4, 5, 2, 4, 2, 0, 0, 0)};
    tbl[3]  = '{16'h4315, 16'h0000, 16'h0000, 0, 5, mk(1, 1, 0, 0, 3, 5, 0, 0, 0, 1, 0, 0)};
    tbl[4]  = '{16'h3FFF, 16'h0000, 16'h0000, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFE, 0)};
    tbl[5]  = '{16'h0000, 16'h0000, 16'h0000, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[6]  = '{16'h1095, 16'h0006, 16'h0000, 0, 0, mk(2, 1, 0, 0, 5, 5, 6, 0, 1, 0, 0, 0)};
    tbl[7]  = '{16'h4222, 16'h0000, 16'h0000, 0, 0, mk(1, 2, 0, 0, 2, 2, 0, 0, 0, 1, 0, 0)};
    tbl[8]  = '{16'h4210, 16'hABCD, 16'h0000, 2, 0, mk(1, 1, 0, 0, 2, 0, 'hABCD, 0, 1, 0, 0, 0)};
    tbl[9]  = '{16'h2001, 16'h0000, 16'h0000, 0, 0, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0)};
    tbl[10] = '{16'h5AF4, 16'h5555, 16'h0000, 1, 2, mk(1, 3, 1, 1, 10, 4, 0, 'h5555, 1, 0, 0, 0)};

    bus.fetch_ack = 1'b0;
    bus.mdb_in    = 16'h0;
    bus.dec_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_instr(tbl[i].op, tbl[i].w1, tbl[i].w2, tbl[i].e, tbl[i].gap, tbl[i].hold, $sformatf("vec%0d", i));

    // Flush together with the source-extension ack: word dropped, nothing issued.
    @(posedge clk); #1;
    bus.fetch_ack = 1'b1; bus.mdb_in = 16'h4035;
    @(posedge clk); #1;
    bus.mdb_in = 16'h1234; flush = 1'b1;
    @(negedge clk);
    chk("flush_src.pc_inc", 32'(bus.pc_inc), 0);
    @(posedge clk); #1;
    bus.fetch_ack = 1'b0; flush = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("flush_src.dec_valid", 32'(bus.dec_valid), 0);
      chk("flush_src.fetch_req", 32'(bus.fetch_req), 1);
    end
    run_instr(tbl[0].op, 16'h0, 16'h0, tbl[0].e, 0, 0, "after_flush");

    // Flush and dec_ready together in ISSUE drop the bundle.
    @(posedge clk); #1;
    bus.fetch_ack = 1'b1; bus.mdb_in = 16'h4405;
    @(posedge clk); #1;
    bus.fetch_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_issue.valid_before", 32'(bus.dec_valid), 1);
    flush = 1'b1; bus.dec_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.dec_ready = 1'b0;
    @(negedge clk);
    chk("flush_issue.dec_valid", 32'(bus.dec_valid), 0);
    chk("flush_issue.fetch_req", 32'(bus.fetch_req), 1);

    // Reset while waiting for the destination extension word.
    @(posedge clk); #1;
    bus.fetch_ack = 1'b1; bus.mdb_in = 16'h4495;
    @(posedge clk); #1;
    bus.mdb_in = 16'h0002;
    @(posedge clk); #1;
    bus.fetch_ack = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_dst.pre_fetch_req", 32'(bus.fetch_req), 1);
    chk("rst_dst.pre_n_ext", 32'(bus.n_ext), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst_dst");
    @(negedge clk);
    chk("rst_dst.resume_fetch_req", 32'(bus.fetch_req), 1);
    run_instr(tbl[2].op, tbl[2].w1, tbl[2].w2, tbl[2].e, 0, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      op = 16'($urandom);
      w1 = 16'($urandom);
      w2 = 16'($urandom);
      e = model(op, w1, w2);
      run_instr(op, w1, w2, e, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                $sformatf("rnd%0d_%04h", i, op));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
